// File: rtl/row_config_loader.sv
// row_config_loader
// Streams a configuration bitstream, one WORD_W-bit word at a time, into a
// serial row programming chain of NUM_CELLS*CELL_BITS bits. A pass either
// loads the chain or verifies it by comparing the bit coming back from the
// chain tail with the bit being shifted in.
//
// Ports
//   prog_clk  in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a pass (honoured only when idle)
//   verify    in   pass mode sampled with start: 0 = load, 1 = verify
//   abort     in   cancel the pass in progress (sets error)
//   s_data    in   bitstream word
//   s_valid   in   s_data valid
//   s_ready   out  loader accepts a word (fetch phase only)
//   prog_out  out  serial bit to the chain head
//   prog_en   out  chain shift enable
//   prog_in   in   serial bit from the chain tail
//   busy      out  pass in progress
//   done      out  one-cycle pass-complete pulse
//   error     out  sticky verify mismatch / abort flag
//   bit_cnt   out  bits shifted in the current pass
module row_config_loader #(
  parameter int NUM_CELLS = 8,
  parameter int CELL_BITS = 32,
  parameter int WORD_W    = 8,
  parameter bit REVERSE   = 1'b0
) (
  input  logic                                      prog_clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      verify,
  input  logic                                      abort,
  input  logic [WORD_W-1:0]                         s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  output logic                                      prog_out,
  output logic                                      prog_en,
  input  logic                                      prog_in,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  output logic [$clog2(NUM_CELLS*CELL_BITS+1)-1:0]  bit_cnt
);

  localparam int TOTAL = NUM_CELLS * CELL_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  // The chain length must be a whole number of words.
  generate
    if ((TOTAL % WORD_W) != 0) begin : g_bad_word_width
      $error("row_config_loader: NUM_CELLS*CELL_BITS must be a multiple of WORD_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WORD_W-1:0]  word_r;
  logic [IDX_W-1:0]   idx_r;
  logic               verify_r;
  logic               error_r;
  logic [CNT_W-1:0]   bit_cnt_r;

  logic               shift_bit_s;
  logic [WORD_W-1:0]  word_shifted_s;
  logic               last_bit_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // The word register is consumed from one end, so the current bit is
  // always at a fixed position and no variable bit select is needed.
  assign shift_bit_s    = REVERSE ? word_r[WORD_W-1] : word_r[0];
  assign word_shifted_s = REVERSE ? (word_r << 1) : (word_r >> 1);
  assign last_bit_s     = (idx_r == LAST_IDX);
  assign cnt_inc_s      = bit_cnt_r + CNT_W'(1);

  // Outputs are pure decodes of registered state, so the asynchronous
  // reset clears them immediately without waiting for an edge.
  assign s_ready  = (state_r == FETCH);
  assign prog_en  = (state_r == SHIFT);
  assign prog_out = (state_r == SHIFT) & shift_bit_s;
  assign busy     = (state_r != IDLE);
  assign done     = (state_r == DONE);
  assign error    = error_r;
  assign bit_cnt  = bit_cnt_r;

  // State register.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort only matters while a word is pending or shifting.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (s_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (last_bit_s) begin
          if (cnt_inc_s == TOTAL_C) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: pass mode, word shifter, per-word bit index, count and error.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      word_r    <= '0;
      idx_r     <= '0;
      verify_r  <= 1'b0;
      error_r   <= 1'b0;
      bit_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            verify_r  <= verify;
            error_r   <= 1'b0;
            bit_cnt_r <= '0;
            idx_r     <= '0;
          end
        end
        FETCH: begin
          if (abort) begin
            error_r <= 1'b1;
          end else if (s_valid) begin
            word_r <= s_data;
            idx_r  <= '0;
          end
        end
        SHIFT: begin
          // The chain tail is compared with the bit driven during this cycle.
          if (abort || (verify_r && (prog_in != shift_bit_s))) begin
            error_r <= 1'b1;
          end
          if (!abort) begin
            word_r    <= word_shifted_s;
            idx_r     <= idx_r + IDX_W'(1);
            bit_cnt_r <= cnt_inc_s;
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/row_config_loader.md
ROW_CONFIG_LOADER -- requirements
Module: row_config_loader

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 8: number of cells in the row programming chain.
REQ-002 SHALL have parameter CELL_BITS, default 32: configuration bits per cell.
REQ-003 SHALL have parameter WORD_W, default 8: bitstream word width; NUM_CELLS*CELL_BITS SHALL be a multiple of WORD_W, else elaboration error.
REQ-004 SHALL have parameter REVERSE, default 0: 0 = word shifted LSB-first, 1 = MSB-first (even-row bit order).
REQ-005 SHALL use one clock and an asynchronous, active-high reset; these are the first two ports below.
REQ-006 prog_clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
REQ-009 verify  input  1  pass mode, sampled with start: 0 = load, 1 = verify.
REQ-010 abort  input  1  synchronous pass cancel.
REQ-011 s_data  input  WORD_W  bitstream word.
REQ-012 s_valid  input  1  s_data valid.
REQ-013 s_ready  output  1  loader accepts a word.
REQ-014 prog_out  output  1  serial bit to the chain head.
REQ-015 prog_en  output  1  chain shift enable.
REQ-016 prog_in  input  1  serial bit from the chain tail.
REQ-017 busy  output  1  pass in progress.
REQ-018 done  output  1  one-cycle pass-complete pulse.
REQ-019 error  output  1  sticky verify mismatch or abort flag.
REQ-020 bit_cnt  output  clog2(NUM_CELLS*CELL_BITS+1)  bits shifted in the current pass.

Function
REQ-021 States SHALL be IDLE, FETCH, SHIFT, DONE; TOTAL = NUM_CELLS*CELL_BITS.
REQ-022 IDLE + start: latch verify, clear error and bit_cnt, go to FETCH next cycle; busy=1 in FETCH, SHIFT, DONE.
REQ-023 s_ready SHALL be 1 only in FETCH; a word transfers on the edge with s_valid & s_ready, then FETCH -> SHIFT.
REQ-024 FETCH with s_valid=0 SHALL wait indefinitely, prog_en=0.
REQ-025 SHIFT SHALL last exactly WORD_W cycles, prog_en=1 each cycle, prog_out = word bit 0..WORD_W-1 (REVERSE=0) or WORD_W-1..0 (REVERSE=1).
REQ-026 bit_cnt SHALL increment by 1 on each SHIFT edge and never exceed TOTAL.
REQ-027 After the last SHIFT cycle of a word: bit_cnt < TOTAL -> FETCH; bit_cnt = TOTAL -> DONE.
REQ-028 DONE SHALL last one cycle with done=1, then IDLE; prog_en=0, prog_out=0 outside SHIFT.
REQ-029 Verify mode SHALL compare prog_in with prog_out on every SHIFT edge; any mismatch sets error, which holds until next accepted start or rst.
REQ-030 Load mode SHALL ignore prog_in and never set error from it.
REQ-031 abort in FETCH or SHIFT SHALL go to IDLE next edge, set error, drop prog_en, emit no done; abort in IDLE or DONE SHALL be ignored.
REQ-032 start outside IDLE SHALL be ignored; abort and start in the same IDLE cycle: start wins.
REQ-033 A word accepted in FETCH SHALL never be re-requested; exactly TOTAL/WORD_W transfers per completed pass.

Reset
REQ-034 rst=1 SHALL immediately force IDLE and s_ready=0, prog_out=0, prog_en=0, busy=0, done=0, error=0, bit_cnt=0, regardless of clock.
REQ-035 rst asserted mid-SHIFT SHALL drop prog_en without waiting for an edge; after release the block SHALL stay IDLE until start.

Verification
REQ-036 NUM_CELLS=2, CELL_BITS=8, WORD_W=8, REVERSE=0, load, words 0xA5,0x3C, s_valid always 1 -> prog_out 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, prog_en high 16 cycles, done one cycle after bit_cnt=16, error=0.
REQ-037 Same with REVERSE=1, word 0xA5 -> prog_out 1,0,1,0,0,1,0,1 reversed order (MSB first) = 1,0,1,0,0,1,0,1; word 0x3C -> 0,0,1,1,1,1,0,0; check bit order against model.
REQ-038 Verify pass with prog_in looped from a 16-bit model chain preloaded by REQ-036 pass -> error=0; flip one chain bit -> error=1 after that bit, done still pulses.
REQ-039 s_valid held low 5 cycles in FETCH -> prog_en=0, bit_cnt frozen, s_ready=1 throughout; resumes correctly.
REQ-040 abort at bit_cnt=5 -> IDLE next edge, error=1, no done; rst pulsed at bit_cnt=9 of new pass -> all outputs zero immediately.
